// File: rtl/vco_cal_pkg.sv
// Shared types and widths for the VCO frequency calibration block.
package vco_cal_pkg;

    localparam int CNT_W = 16;  // phase-step count width
    localparam int IDX_W = 6;   // ring phase index width (0..63)

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DECIDE,
        ST_DONE
    } cal_state_t;

endpackage

// File: rtl/vco_phase_decode.sv
// Synchronizes the ring taps, turns the tap pattern into a phase index and
// reports how far the ring advanced since the previous clock (mod 64).
module vco_phase_decode
    import vco_cal_pkg::*;
#(
    parameter int NPH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NPH-1:0] phase_p,
    output idx_t           delta
);

    logic [NPH-1:0] meta_p0;
    logic [NPH-1:0] sync_p1;
    logic [NPH-1:0] q;
    idx_t           idx;
    idx_t           idx_prev_p2;

    function automatic idx_t popcount(input logic [NPH-1:0] v);
        idx_t n;
        n = '0;
        for (int i = 0; i < NPH; i++) begin
            n = n + idx_t'(v[i]);
        end
        return n;
    endfunction

    // Two-flop synchronizer per tap, plus the previous-cycle index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0     <= '0;
            sync_p1     <= '0;
            idx_prev_p2 <= '0;
        end else begin
            meta_p0     <= phase_p;
            sync_p1     <= meta_p0;
            idx_prev_p2 <= idx;
        end
    end

    // Undo the alternating inversion of ring stages, then count ones to get
    // the index; the upper half of the cycle is marked by the last tap.
    always_comb begin
        for (int i = 0; i < NPH; i++) begin
            q[i] = sync_p1[i] ^ i[0];
        end
        if (q[NPH-1]) begin
            idx = idx_t'(NPH) + popcount(~q);
        end else begin
            idx = popcount(q);
        end
    end

    // Unsigned 6-bit subtraction wraps naturally across the 63 -> 0 seam.
    assign delta = idx - idx_prev_p2;

endmodule

// File: rtl/vco_freq_cal.sv
// Successive-approximation trim of a ring oscillator: each trim bit is
// settled, measured over a fixed window and kept or cleared against target.
module vco_freq_cal
    import vco_cal_pkg::*;
#(
    parameter int NPH        = 32,
    parameter int WIN_LOG2   = 8,
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cal_start,
    input  logic              cal_abort,
    input  logic [15:0]       target_cnt,
    input  logic [NPH-1:0]    phase_p,
    output logic              sw_vco,
    output logic [TRIM_W-1:0] trim_code,
    output logic              cal_busy,
    output logic              cal_done,
    output logic [15:0]       meas_cnt
);

    localparam int                PTR_W       = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int                WIN_CYC     = 1 << WIN_LOG2;
    localparam cnt_t              SETTLE_LAST = cnt_t'(SETTLE_CYC - 1);
    localparam cnt_t              WIN_LAST    = cnt_t'(WIN_CYC - 1);
    localparam logic [PTR_W-1:0]  PTR_TOP     = PTR_W'(TRIM_W - 1);
    localparam logic [TRIM_W-1:0] MID_CODE    = {1'b1, {(TRIM_W-1){1'b0}}};

    cal_state_t        state;
    logic [PTR_W-1:0]  ptr;
    cnt_t              cnt;
    cnt_t              target_q;
    cnt_t              acc;
    cnt_t              acc_next;
    idx_t              delta;
    logic [TRIM_W-1:0] sar_trim;

    function automatic cnt_t sat_add(input cnt_t a, input idx_t d);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W + 1 - IDX_W){1'b0}}, d};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    vco_phase_decode #(
        .NPH (NPH)
    ) u_decode (
        .clk     (clk),
        .rst_n   (rst_n),
        .phase_p (phase_p),
        .delta   (delta)
    );

    assign acc_next = sat_add(acc, delta);

    // Next trim code: drop the bit under test if the ring ran too fast,
    // then tentatively raise the next lower bit.
    always_comb begin
        sar_trim = trim_code;
        if (meas_cnt > target_q) begin
            sar_trim[ptr] = 1'b0;
        end
        if (ptr != '0) begin
            sar_trim[ptr - 1'b1] = 1'b1;
        end
    end

    // Calibration sequencer; abort outranks everything, including start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sw_vco    <= 1'b0;
            cal_busy  <= 1'b0;
            cal_done  <= 1'b0;
            trim_code <= MID_CODE;
            ptr       <= PTR_TOP;
            cnt       <= '0;
            target_q  <= '0;
            acc       <= '0;
            meas_cnt  <= '0;
        end else if (cal_abort) begin
            state    <= ST_IDLE;
            sw_vco   <= 1'b0;
            cal_busy <= 1'b0;
            cal_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (cal_start) begin
                        state     <= ST_SETTLE;
                        trim_code <= MID_CODE;
                        ptr       <= PTR_TOP;
                        sw_vco    <= 1'b1;
                        cal_busy  <= 1'b1;
                        cal_done  <= 1'b0;
                        cnt       <= '0;
                        target_q  <= target_cnt;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_MEASURE;
                        cnt   <= '0;
                        acc   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    acc <= acc_next;
                    if (cnt == WIN_LAST) begin
                        state    <= ST_DECIDE;
                        meas_cnt <= acc_next;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    trim_code <= sar_trim;
                    if (ptr != '0) begin
                        ptr   <= ptr - 1'b1;
                        state <= ST_SETTLE;
                    end else begin
                        state    <= ST_DONE;
                        cal_busy <= 1'b0;
                        cal_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vco_freq_cal.sv
// Bench for vco_freq_cal: a ring model advances its phase by trim_code (or a
// fixed step) per clock, and expected window counts go through a scoreboard.
module tb_vco_freq_cal;

    localparam int NPH        = 32;
    localparam int TRIM_W     = 6;
    localparam int SETTLE_CYC = 16;
    localparam int WIN        = 16;   // 2^4 for the main instance
    localparam int GAIN       = WIN;  // count per window per unit of trim

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              cal_start, cal_abort;
    logic [15:0]       target_cnt;
    logic [NPH-1:0]    phase_p = 32'hAAAA_AAAA;
    logic              sw_vco, cal_busy, cal_done;
    logic [TRIM_W-1:0] trim_code;
    logic [15:0]       meas_cnt;

    logic              s_cal_start, s_cal_abort;
    logic [15:0]       s_target = 16'hFFFF;
    logic [NPH-1:0]    s_phase_p = 32'hAAAA_AAAA;
    logic              s_sw_vco, s_cal_busy, s_cal_done;
    logic [TRIM_W-1:0] s_trim_code;
    logic [15:0]       s_meas_cnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    int ring_idx   = 0;
    int s_ring_idx = 0;
    bit fixed_mode = 1'b0;
    int fixed_step = 0;

    vco_freq_cal #(.NPH(NPH), .WIN_LOG2(4), .TRIM_W(TRIM_W), .SETTLE_CYC(SETTLE_CYC)) u_dut (
        .clk(clk), .rst_n(rst_n), .cal_start(cal_start), .cal_abort(cal_abort),
        .target_cnt(target_cnt), .phase_p(phase_p), .sw_vco(sw_vco),
        .trim_code(trim_code), .cal_busy(cal_busy), .cal_done(cal_done), .meas_cnt(meas_cnt)
    );

    vco_freq_cal #(.NPH(NPH), .WIN_LOG2(12), .TRIM_W(TRIM_W), .SETTLE_CYC(SETTLE_CYC)) u_sat (
        .clk(clk), .rst_n(rst_n), .cal_start(s_cal_start), .cal_abort(s_cal_abort),
        .target_cnt(s_target), .phase_p(s_phase_p), .sw_vco(s_sw_vco),
        .trim_code(s_trim_code), .cal_busy(s_cal_busy), .cal_done(s_cal_done), .meas_cnt(s_meas_cnt)
    );

    // Tap pattern of a ring sitting at phase index k (odd stages inverted).
    function automatic logic [31:0] phase_of(input int k);
        logic [31:0] q;
        if (k < 32) q = (32'h1 << k) - 32'h1;
        else        q = ~((32'h1 << (k - 32)) - 32'h1);
        return q ^ 32'hAAAA_AAAA;
    endfunction

    // Trim code in use during SAR round 'rounds' for a given target.
    function automatic int sar_code(input int target, input int rounds);
        int code;
        int b;
        code = 1 << (TRIM_W - 1);
        for (int r = 0; r < rounds; r++) begin
            b = TRIM_W - 1 - r;
            if (GAIN * code > target) code = code & ~(1 << b);
            if (b > 0) code = code | (1 << (b - 1));
        end
        return code;
    endfunction

    // Largest code whose window count does not exceed target.
    function automatic int floor_code(input int target);
        int best;
        best = 0;
        for (int c = 0; c < 64; c++) if (GAIN * c <= target) best = c;
        return best;
    endfunction

    // Ring models, updated away from the sampling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (fixed_mode)  ring_idx = (ring_idx + fixed_step) % 64;
            else if (sw_vco) ring_idx = (ring_idx + int'(trim_code)) % 64;
            phase_p    = phase_of(ring_idx);
            s_ring_idx = (s_ring_idx + 63) % 64;
            s_phase_p  = phase_of(s_ring_idx);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (sw_vco !== 1'b0) begin errors++; $display("FAIL reset_sw_vco got %0b exp 0", sw_vco); end
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", cal_busy); end
        checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", cal_done); end
        checks++; if (trim_code !== 6'd32) begin errors++; $display("FAIL reset_trim got %0d exp 32", trim_code); end
        checks++; if (meas_cnt !== 16'd0) begin errors++; $display("FAIL reset_meas got %0d exp 0", meas_cnt); end
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    // Full calibration with window-by-window scoreboard and latency checks.
    task automatic run_sar(input string tag, input int target);
        int exp_v;
        for (int w = 0; w < TRIM_W; w++) exp_q.push_back(GAIN * sar_code(target, w));
        target_cnt = 16'(target);
        cal_start  = 1'b1;
        tick();
        cal_start  = 1'b0;
        target_cnt = ~16'(target);
        for (int w = 0; w < TRIM_W; w++) begin
            repeat ((w == 0) ? SETTLE_CYC + WIN : SETTLE_CYC + WIN + 1) tick();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL %s_win%0d got %0d exp nothing queued", tag, w, meas_cnt);
            end else begin
                exp_v = exp_q.pop_front();
                if (int'(meas_cnt) != exp_v) begin
                    errors++; $display("FAIL %s_win%0d got %0d exp %0d", tag, w, meas_cnt, exp_v);
                end
            end
        end
        checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL %s_done_early got %0b exp 0", tag, cal_done); end
        tick();
        checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL %s_done_at_latency got %0b exp 1", tag, cal_done); end
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_in_done got %0b exp 0", tag, cal_busy); end
    endtask

    task automatic test_convergence();
        int exp_trim;
        fixed_mode = 1'b0;
        exp_trim   = floor_code(592);
        run_sar("conv", 592);
        checks++; if (int'(trim_code) != exp_trim) begin errors++; $display("FAIL conv_trim got %0d exp %0d", trim_code, exp_trim); end
        repeat (5) tick();
        checks++; if (sw_vco !== 1'b1) begin errors++; $display("FAIL conv_sw_vco_hold got %0b exp 1", sw_vco); end
        checks++; if (int'(trim_code) != exp_trim) begin errors++; $display("FAIL conv_trim_hold got %0d exp %0d", trim_code, exp_trim); end
        checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL conv_done_hold got %0b exp 1", cal_done); end
    endtask

    // Restarts straight from DONE; no code fits target 0, so result is 0.
    task automatic test_floor();
        run_sar("floor", 0);
        checks++; if (trim_code !== 6'd0) begin errors++; $display("FAIL floor_trim got %0d exp 0", trim_code); end
    endtask

    task automatic test_wrap();
        int exp_v;
        fixed_mode = 1'b1;
        fixed_step = 60;
        exp_q.push_back(WIN * 60);
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        repeat (SETTLE_CYC + WIN) tick();
        exp_v = exp_q.pop_front();
        checks++; if (int'(meas_cnt) != exp_v) begin errors++; $display("FAIL wrap_meas got %0d exp %0d", meas_cnt, exp_v); end
        checks++; if (cal_busy !== 1'b1) begin errors++; $display("FAIL wrap_busy got %0b exp 1", cal_busy); end
        cal_abort = 1'b1;
        tick();
        cal_abort = 1'b0;
        fixed_mode = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_abort();
        int exp_v;
        int exp_trim;
        exp_q.push_back(GAIN * sar_code(592, 0));
        exp_q.push_back(GAIN * sar_code(592, 1));
        exp_trim   = sar_code(592, 2);
        target_cnt = 16'd592;
        cal_start  = 1'b1;
        tick();
        cal_start  = 1'b0;
        repeat (32) tick();
        exp_v = exp_q.pop_front();
        checks++; if (int'(meas_cnt) != exp_v) begin errors++; $display("FAIL abort_win0 got %0d exp %0d", meas_cnt, exp_v); end
        repeat (8) tick();
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        checks++; if (cal_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_ignore_start got %0b exp 1", cal_busy); end
        repeat (24) tick();
        exp_v = exp_q.pop_front();
        checks++; if (int'(meas_cnt) != exp_v) begin errors++; $display("FAIL abort_win1_no_restart got %0d exp %0d", meas_cnt, exp_v); end
        repeat (25) tick();
        cal_abort = 1'b1;
        tick();
        cal_abort = 1'b0;
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", cal_busy); end
        checks++; if (sw_vco !== 1'b0) begin errors++; $display("FAIL abort_sw_vco got %0b exp 0", sw_vco); end
        checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL abort_done got %0b exp 0", cal_done); end
        checks++; if (int'(trim_code) != exp_trim) begin errors++; $display("FAIL abort_trim_hold got %0d exp %0d", trim_code, exp_trim); end
        checks++; if (int'(meas_cnt) != exp_v) begin errors++; $display("FAIL abort_meas_hold got %0d exp %0d", meas_cnt, exp_v); end
        repeat (5) tick();
        cal_start = 1'b1;
        cal_abort = 1'b1;
        tick();
        cal_start = 1'b0;
        cal_abort = 1'b0;
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL abort_priority_busy got %0b exp 0", cal_busy); end
        checks++; if (sw_vco !== 1'b0) begin errors++; $display("FAIL abort_priority_sw_vco got %0b exp 0", sw_vco); end
    endtask

    // Reset lands in the second MEASURE, where trim and meas_cnt are non-reset.
    task automatic test_reset_mid_measure();
        target_cnt = 16'd592;
        cal_start  = 1'b1;
        tick();
        cal_start  = 1'b0;
        repeat (55) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sw_vco !== 1'b0) begin errors++; $display("FAIL rstmid_sw_vco got %0b exp 0", sw_vco); end
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b exp 0", cal_busy); end
        checks++; if (trim_code !== 6'd32) begin errors++; $display("FAIL rstmid_trim got %0d exp 32", trim_code); end
        checks++; if (meas_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_meas got %0d exp 0", meas_cnt); end
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_busy got %0b exp 0", cal_busy); end
        checks++; if (meas_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_idle_meas got %0d exp 0", meas_cnt); end
    endtask

    task automatic test_saturation();
        int exp_v;
        exp_q.push_back(16'hFFFF);
        s_cal_start = 1'b1;
        tick();
        s_cal_start = 1'b0;
        repeat (SETTLE_CYC + 4096) tick();
        exp_v = exp_q.pop_front();
        checks++; if (int'(s_meas_cnt) != exp_v) begin errors++; $display("FAIL sat_meas got %0d exp %0d", s_meas_cnt, exp_v); end
        checks++; if (s_cal_busy !== 1'b1) begin errors++; $display("FAIL sat_busy got %0b exp 1", s_cal_busy); end
        s_cal_abort = 1'b1;
        tick();
        s_cal_abort = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        cal_start   = 1'b0;
        cal_abort   = 1'b0;
        target_cnt  = 16'd0;
        s_cal_start = 1'b0;
        s_cal_abort = 1'b0;
        test_reset();
        test_convergence();
        test_floor();
        test_wrap();
        test_abort();
        test_reset_mid_measure();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
